// File: rtl/mrd_mem_pkt.sv
// rtl/mrd_mem_pkt.sv - shared constants and types for the mixed-radix DFT input packer
package mrd_mem_pkt;

    localparam int WDATA   = 18;
    localparam int WPTS    = 12;
    localparam int LANES   = 4;
    localparam int MIN_PTS = 12;
    localparam int MAX_PTS = 1200;

    typedef logic signed [WDATA-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PACK    = 2'd1,
        DISCARD = 2'd2
    } in_pack_st_t;

endpackage

// File: rtl/mrd_lane_acc.sv
// rtl/mrd_lane_acc.sv - 4-lane write-by-index sample buffer with zero-on-clear
module mrd_lane_acc
    import mrd_mem_pkt::*;
#(
    parameter int wDATA = WDATA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [1:0]             wr_idx,
    input  logic [wDATA-1:0]       wr_real,
    input  logic [wDATA-1:0]       wr_imag,
    output logic [LANES*wDATA-1:0] lanes_real,
    output logic [LANES*wDATA-1:0] lanes_imag
);

    logic [wDATA-1:0] re_q [LANES];
    logic [wDATA-1:0] im_q [LANES];

    // a write beats a clear on its own lane so a restart can seed lane 0 while zeroing the rest
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (!rst_n) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end else if (wr_en && (wr_idx == k[1:0])) begin
                re_q[k] <= wr_real;
                im_q[k] <= wr_imag;
            end else if (clr) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_flat
        assign lanes_real[g*wDATA +: wDATA] = re_q[g];
        assign lanes_imag[g*wDATA +: wDATA] = im_q[g];
    end

endmodule

// File: rtl/mrd_in_pack_p4.sv
// rtl/mrd_in_pack_p4.sv - 1-to-4 lane input packer with length check; err_cnt under MRD_IN_PACK_ERRCNT_EN
module mrd_in_pack_p4
    import mrd_mem_pkt::*;
#(
    parameter int wDATA   = WDATA,
    parameter int wPTS    = WPTS,
    parameter int MAX_PTS = mrd_mem_pkt::MAX_PTS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [wDATA-1:0]       in_real,
    input  logic [wDATA-1:0]       in_imag,
    input  logic [wPTS-1:0]        in_dftpts,
    input  logic [5:0]             in_size,
    input  logic                   mem_sink_ready,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [LANES*wDATA-1:0] out_real,
    output logic [LANES*wDATA-1:0] out_imag,
    output logic [wPTS-1:0]        out_dftpts,
    output logic [5:0]             out_size,
    output logic                   err_len,
    output logic                   err_drop
`ifdef MRD_IN_PACK_ERRCNT_EN
    ,
    output logic [15:0]            err_cnt
`endif
);

    in_pack_st_t state_q, state_d;
    logic [wPTS-1:0] cnt_q, cnt_d;
    logic            first_q, first_d;

    logic            acc_clr, acc_wr;
    logic [1:0]      acc_idx;
    logic [LANES*wDATA-1:0] acc_real, acc_imag;
    logic [LANES*wDATA-1:0] word_real, word_imag;

    logic emit, emit_sop, emit_eop, emit_merge;
    logic len_err, drop_err, sop_try, admit;
    logic legal, at_last;

    assign in_ready = (state_q == IDLE) && mem_sink_ready;
    assign legal    = (in_dftpts >= wPTS'(MIN_PTS)) && (in_dftpts <= wPTS'(MAX_PTS))
                      && (in_dftpts[1:0] == 2'b00);
    // out_dftpts doubles as the length register of the packet in flight
    assign at_last  = (cnt_q == out_dftpts - wPTS'(1));

    mrd_lane_acc #(.wDATA(wDATA)) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (acc_clr),
        .wr_en      (acc_wr),
        .wr_idx     (acc_idx),
        .wr_real    (in_real),
        .wr_imag    (in_imag),
        .lanes_real (acc_real),
        .lanes_imag (acc_imag)
    );

    // next state, lane writes and word emission; a sop inside PACK flushes then restarts
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        acc_clr    = 1'b0;
        acc_wr     = 1'b0;
        acc_idx    = cnt_q[1:0];
        emit       = 1'b0;
        emit_sop   = 1'b0;
        emit_eop   = 1'b0;
        emit_merge = 1'b0;
        len_err    = 1'b0;
        drop_err   = 1'b0;
        sop_try    = 1'b0;
        admit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_sop) sop_try = 1'b1;
            end
            PACK: begin
                if (in_valid && in_sop) begin
                    emit     = 1'b1;
                    emit_sop = first_q;
                    emit_eop = 1'b1;
                    len_err  = 1'b1;
                    acc_clr  = 1'b1;
                    sop_try  = 1'b1;
                end else if (in_valid) begin
                    emit_merge = 1'b1;
                    if (in_eop || at_last) begin
                        emit     = 1'b1;
                        emit_sop = first_q;
                        emit_eop = 1'b1;
                        len_err  = !(in_eop && at_last);
                        acc_clr  = 1'b1;
                        state_d  = in_eop ? IDLE : DISCARD;
                    end else begin
                        cnt_d = cnt_q + wPTS'(1);
                        if (cnt_q[1:0] == 2'd3) begin
                            emit     = 1'b1;
                            emit_sop = first_q;
                            acc_clr  = 1'b1;
                            first_d  = 1'b0;
                        end else begin
                            acc_wr = 1'b1;
                        end
                    end
                end
            end
            DISCARD: begin
                if (in_valid && in_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a single-sample packet (sop with eop) can never meet the minimum length, so it is rejected
        if (sop_try) begin
            if (mem_sink_ready && legal && !in_eop) begin
                admit   = 1'b1;
                state_d = PACK;
                cnt_d   = wPTS'(1);
                first_d = 1'b1;
                acc_clr = 1'b1;
                acc_wr  = 1'b1;
                acc_idx = 2'd0;
            end else begin
                drop_err = 1'b1;
                state_d  = in_eop ? IDLE : DISCARD;
            end
        end
    end

    // the word closed by this cycle's sample includes that sample on top of the buffered lanes
    always_comb begin
        word_real = acc_real;
        word_imag = acc_imag;
        if (emit_merge) begin
            word_real[cnt_q[1:0]*wDATA +: wDATA] = in_real;
            word_imag[cnt_q[1:0]*wDATA +: wDATA] = in_imag;
        end
    end

    // state, counters and the output register, which is independent of the lane buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_real   <= '0;
            out_imag   <= '0;
            out_dftpts <= '0;
            out_size   <= '0;
            err_len    <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            out_valid <= emit;
            out_sop   <= emit_sop;
            out_eop   <= emit_eop;
            err_len   <= len_err;
            err_drop  <= drop_err;
            if (emit) begin
                out_real <= word_real;
                out_imag <= word_imag;
            end
            if (admit) begin
                out_dftpts <= in_dftpts;
                out_size   <= in_size;
            end
        end
    end

`ifdef MRD_IN_PACK_ERRCNT_EN
    // saturating error counter; simultaneous length and drop errors count once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((len_err || drop_err) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mrd_in_pack_p4.sv
// tb/tb_mrd_in_pack_p4.sv - directed self-checking bench for mrd_in_pack_p4
module tb_mrd_in_pack_p4;

    localparam int W = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [W-1:0]  in_real = '0;
    logic [W-1:0]  in_imag = '0;
    logic [11:0]   in_dftpts = '0;
    logic [5:0]    in_size = '0;
    logic          mem_sink_ready = 1'b1;
    logic          in_ready, out_valid, out_sop, out_eop, err_len, err_drop;
    logic [4*W-1:0] out_real, out_imag;
    logic [11:0]   out_dftpts;
    logic [5:0]    out_size;
`ifdef MRD_IN_PACK_ERRCNT_EN
    logic [15:0]   err_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int nvalid, ndrop;

    always #5 clk = ~clk;

    mrd_in_pack_p4 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_real        (in_real),
        .in_imag        (in_imag),
        .in_dftpts      (in_dftpts),
        .in_size        (in_size),
        .mem_sink_ready (mem_sink_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_real       (out_real),
        .out_imag       (out_imag),
        .out_dftpts     (out_dftpts),
        .out_size       (out_size),
        .err_len        (err_len),
        .err_drop       (err_drop)
`ifdef MRD_IN_PACK_ERRCNT_EN
        ,
        .err_cnt        (err_cnt)
`endif
    );

    function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {18'(d), 18'(c), 18'(b), 18'(a)};
    endfunction

    function automatic int im(input int x);
        return (x == 0) ? 0 : x + 1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic samp(input int v, input bit sop, input bit eop);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_real  = 18'(v);
        in_imag  = 18'(v + 1000);
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic exp_word(input string tag, input bit sop, input bit eop, input bit elen,
                            input int a, input int b, input int c, input int d);
        chk({tag, ".valid"}, 72'(out_valid), 72'(1'b1));
        chk({tag, ".sop"},   72'(out_sop),   72'(sop));
        chk({tag, ".eop"},   72'(out_eop),   72'(eop));
        chk({tag, ".elen"},  72'(err_len),   72'(elen));
        chk({tag, ".edrop"}, 72'(err_drop),  72'(1'b0));
        chk({tag, ".real"},  out_real, pack4(a, b, c, d));
        chk({tag, ".imag"},  out_imag, pack4(im(a), im(b), im(c), im(d)));
    endtask

    task automatic exp_none(input string tag);
        chk({tag, ".novalid"}, 72'(out_valid), 72'(1'b0));
    endtask

    initial begin
        // reset state
        in_dftpts = 12'd12;
        tick();
        tick();
        chk("rst.valid", 72'(out_valid), 72'(1'b0));
        chk("rst.sop",   72'(out_sop),   72'(1'b0));
        chk("rst.eop",   72'(out_eop),   72'(1'b0));
        chk("rst.real",  out_real,       72'(0));
        chk("rst.imag",  out_imag,       72'(0));
        chk("rst.pts",   72'(out_dftpts), 72'(0));
        chk("rst.size",  72'(out_size),  72'(0));
        chk("rst.elen",  72'(err_len),   72'(1'b0));
        chk("rst.edrop", 72'(err_drop),  72'(1'b0));
        chk("rst.ready", 72'(in_ready),  72'(1'b1));
        rst_n = 1'b1;
        tick();

        // 1: dftpts=12, three clean words
        in_dftpts = 12'd12;
        in_size   = 6'd5;
        for (int v = 1; v <= 12; v++) begin
            samp(v, v == 1, v == 12);
            if (v % 4 == 0) exp_word($sformatf("t1.w%0d", v), v == 4, v == 12, 1'b0, v-3, v-2, v-1, v);
            else            exp_none($sformatf("t1.s%0d", v));
        end
        chk("t1.pts",  72'(out_dftpts), 72'(12));
        chk("t1.size", 72'(out_size),   72'(5));
        chk("t1.ready", 72'(in_ready),  72'(1'b1));
        tick();

        // 2: sop while the memory is busy is dropped once and the packet discarded
        mem_sink_ready = 1'b0;
        #1;
        chk("t2.notready", 72'(in_ready), 72'(1'b0));
        samp(50, 1'b1, 1'b0);
        chk("t2.drop",    72'(err_drop),  72'(1'b1));
        chk("t2.novalid", 72'(out_valid), 72'(1'b0));
        mem_sink_ready = 1'b1;
        #1;
        chk("t2.discard_ready", 72'(in_ready), 72'(1'b0));
        nvalid = 0;
        ndrop  = 0;
        for (int v = 51; v <= 61; v++) begin
            samp(v, 1'b0, v == 61);
            nvalid += int'(out_valid);
            ndrop  += int'(err_drop);
        end
        chk("t2.nvalid", 72'(nvalid), 72'(0));
        chk("t2.ndrop",  72'(ndrop),  72'(0));
        chk("t2.ready",  72'(in_ready), 72'(1'b1));

        // illegal lengths: not a multiple of 4, below minimum, above maximum
        in_dftpts = 12'd14;
        samp(80, 1'b1, 1'b0);
        chk("il14.drop", 72'(err_drop), 72'(1'b1));
        samp(81, 1'b0, 1'b1);
        exp_none("il14.end");
        in_dftpts = 12'd8;
        samp(82, 1'b1, 1'b0);
        chk("il8.drop", 72'(err_drop), 72'(1'b1));
        samp(83, 1'b0, 1'b1);
        in_dftpts = 12'd1204;
        samp(84, 1'b1, 1'b0);
        chk("il1204.drop", 72'(err_drop), 72'(1'b1));
        samp(85, 1'b0, 1'b1);
        chk("il.pts_held", 72'(out_dftpts), 72'(12));

        // largest legal size is admitted; early eop at sample 2
        in_dftpts = 12'd1200;
        in_size   = 6'd33;
        samp(90, 1'b1, 1'b0);
        chk("max.nodrop", 72'(err_drop),  72'(1'b0));
        chk("max.busy",   72'(in_ready),  72'(1'b0));
        chk("max.pts",    72'(out_dftpts), 72'(1200));
        samp(91, 1'b0, 1'b1);
        exp_word("max.w", 1'b1, 1'b1, 1'b1, 90, 91, 0, 0);

        // 3: dftpts=24, eop at sample 10
        in_dftpts = 12'd24;
        in_size   = 6'd7;
        for (int v = 1; v <= 10; v++) begin
            samp(v, v == 1, v == 10);
            if (v == 10)         exp_word("t3.w10", 1'b0, 1'b1, 1'b1, 9, 10, 0, 0);
            else if (v % 4 == 0) exp_word($sformatf("t3.w%0d", v), v == 4, 1'b0, 1'b0, v-3, v-2, v-1, v);
            else                 exp_none($sformatf("t3.s%0d", v));
        end
        chk("t3.ready", 72'(in_ready), 72'(1'b1));

        // 4: dftpts=12 with 15 samples, eop only on the 15th
        in_dftpts = 12'd12;
        in_size   = 6'd2;
        for (int v = 1; v <= 15; v++) begin
            samp(v, v == 1, v == 15);
            if (v == 12)                  exp_word("t4.w12", 1'b0, 1'b1, 1'b1, 9, 10, 11, 12);
            else if (v % 4 == 0 && v < 12) exp_word($sformatf("t4.w%0d", v), v == 4, 1'b0, 1'b0, v-3, v-2, v-1, v);
            else                          exp_none($sformatf("t4.s%0d", v));
            if (v == 13) chk("t4.discard", 72'(in_ready), 72'(1'b0));
        end
        chk("t4.ready", 72'(in_ready), 72'(1'b1));

        // 5: new sop after sample 6 flushes {5,6,0,0} and starts a dftpts=16 packet
        in_dftpts = 12'd12;
        in_size   = 6'd4;
        for (int v = 1; v <= 6; v++) begin
            samp(v, v == 1, 1'b0);
            if (v == 4) exp_word("t5.w4", 1'b1, 1'b0, 1'b0, 1, 2, 3, 4);
        end
        in_dftpts = 12'd16;
        in_size   = 6'd9;
        samp(101, 1'b1, 1'b0);
        exp_word("t5.flush", 1'b0, 1'b1, 1'b1, 5, 6, 0, 0);
        chk("t5.pts",  72'(out_dftpts), 72'(16));
        chk("t5.size", 72'(out_size),   72'(9));
        for (int v = 102; v <= 116; v++) begin
            samp(v, 1'b0, v == 116);
            if ((v - 100) % 4 == 0) exp_word($sformatf("t5.w%0d", v), v == 104, v == 116, 1'b0, v-3, v-2, v-1, v);
            else                    exp_none($sformatf("t5.s%0d", v));
        end
`ifdef MRD_IN_PACK_ERRCNT_EN
        chk("cnt.total", 72'(err_cnt), 72'(8));
`endif

        // 6: reset in the middle of a packet
        in_dftpts = 12'd12;
        in_size   = 6'd3;
        for (int v = 1; v <= 3; v++) samp(v, v == 1, 1'b0);
        rst_n          = 1'b0;
        mem_sink_ready = 1'b0;
        tick();
        chk("t6.valid",   72'(out_valid),  72'(1'b0));
        chk("t6.pts",     72'(out_dftpts), 72'(0));
        chk("t6.size",    72'(out_size),   72'(0));
        chk("t6.real",    out_real,        72'(0));
        chk("t6.ready0",  72'(in_ready),   72'(1'b0));
        mem_sink_ready = 1'b1;
        #1;
        chk("t6.ready1",  72'(in_ready),   72'(1'b1));
`ifdef MRD_IN_PACK_ERRCNT_EN
        chk("t6.errcnt",  72'(err_cnt),    72'(0));
`endif
        rst_n = 1'b1;
        tick();
        samp(4, 1'b0, 1'b0);
        exp_none("t6.stray");
        for (int v = 21; v <= 32; v++) begin
            samp(v, v == 21, v == 32);
            if (v == 24) exp_word("t6.w24", 1'b1, 1'b0, 1'b0, 21, 22, 23, 24);
            if (v == 32) exp_word("t6.w32", 1'b0, 1'b1, 1'b0, 29, 30, 31, 32);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
